// File: rtl/fpu_result_arbiter.sv
// rtl/fpu_result_arbiter.sv - round-robin merge of FPU unit results into one registered writeback stream
// Optional skid entry enabled by defining FPU_ARB_SKID_EN.
module fpu_result_arbiter #(
  parameter int N_UNITS = 4,
  localparam int UW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [N_UNITS-1:0]   valid_in,
  output logic [N_UNITS-1:0]   ready_out,
  input  logic [32*N_UNITS-1:0] result_in,
  input  logic [5*N_UNITS-1:0] flags_in,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [31:0]          result_out,
  output logic [4:0]           flags_out,
  output logic [UW-1:0]        unit_out,
  input  logic                 fflags_clr,
  output logic [4:0]           fflags
);

  logic [UW-1:0]      ptr;
  logic [UW-1:0]      ptr_next;
  logic [N_UNITS-1:0] grant;
  logic               gnt_any;
  logic [UW-1:0]      gnt_idx;
  logic [UW:0]        cand;
  logic [UW-1:0]      cand_idx;
  logic [31:0]        gnt_res;
  logic [4:0]         gnt_flg;

  logic               valid_q;
  logic [31:0]        res_q;
  logic [4:0]         flg_q;
  logic [UW-1:0]      unit_q;

  logic accept;
  logic xfer;
  logic deliver;

  // Search from ptr upward, wrapping modulo N_UNITS; first valid unit wins.
  always_comb begin
    grant    = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand     = '0;
    cand_idx = '0;
    for (int k = 0; k < N_UNITS; k++) begin
      cand = {1'b0, ptr} + (UW+1)'(k);
      if (cand >= (UW+1)'(N_UNITS)) cand = cand - (UW+1)'(N_UNITS);
      cand_idx = cand[UW-1:0];
      if (!gnt_any && valid_in[cand_idx]) begin
        gnt_any         = 1'b1;
        gnt_idx         = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_res = '0;
    gnt_flg = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (grant[i]) begin
        gnt_res = result_in[32*i +: 32];
        gnt_flg = flags_in[5*i +: 5];
      end
    end
  end

  assign ptr_next   = (gnt_idx == UW'(N_UNITS-1)) ? '0 : gnt_idx + UW'(1);
  assign valid_out  = valid_q && !flush;
  assign result_out = res_q;
  assign flags_out  = flg_q;
  assign unit_out   = unit_q;
  assign deliver    = valid_out && ready_in;
  assign xfer       = gnt_any && accept && !flush;
  assign ready_out  = (accept && !flush) ? grant : '0;

`ifdef FPU_ARB_SKID_EN
  logic          sk_valid;
  logic [31:0]   sk_res;
  logic [4:0]    sk_flg;
  logic [UW-1:0] sk_unit;

  // Accept depends only on registered state, cutting the ready_in -> ready_out path.
  assign accept = !sk_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      res_q    <= '0;
      flg_q    <= '0;
      unit_q   <= '0;
      sk_valid <= 1'b0;
      sk_res   <= '0;
      sk_flg   <= '0;
      sk_unit  <= '0;
    end else if (flush) begin
      valid_q  <= 1'b0;
      res_q    <= '0;
      flg_q    <= '0;
      unit_q   <= '0;
      sk_valid <= 1'b0;
      sk_res   <= '0;
      sk_flg   <= '0;
      sk_unit  <= '0;
    end else if (xfer && valid_q && !ready_in) begin
      sk_valid <= 1'b1;
      sk_res   <= gnt_res;
      sk_flg   <= gnt_flg;
      sk_unit  <= gnt_idx;
    end else if (xfer) begin
      valid_q <= 1'b1;
      res_q   <= gnt_res;
      flg_q   <= gnt_flg;
      unit_q  <= gnt_idx;
    end else if (deliver) begin
      valid_q  <= sk_valid;
      res_q    <= sk_res;
      flg_q    <= sk_flg;
      unit_q   <= sk_unit;
      sk_valid <= 1'b0;
      sk_res   <= '0;
      sk_flg   <= '0;
      sk_unit  <= '0;
    end
  end
`else
  assign accept = !valid_q || ready_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      flg_q   <= '0;
      unit_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      flg_q   <= '0;
      unit_q  <= '0;
    end else if (xfer) begin
      valid_q <= 1'b1;
      res_q   <= gnt_res;
      flg_q   <= gnt_flg;
      unit_q  <= gnt_idx;
    end else if (deliver) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      flg_q   <= '0;
      unit_q  <= '0;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= ptr_next;
    end
  end

  // Flags delivered in the same cycle as a clear are kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fflags <= '0;
    end else if (!flush) begin
      if (fflags_clr) fflags <= deliver ? flags_out : 5'b0;
      else if (deliver) fflags <= fflags | flags_out;
    end
  end

endmodule
